seq_det_ctrl: RTL
=================

Name: seq_det_ctrl

Overview:
- Frame-level controller for an external serial Moore "1010" sequence detector, with overlapping detection and one-cycle output pulses.
- Accepts parallel words over a valid/ready handshake and serializes them MSB-first into the detector's input, one bit per clock, gap-free within a frame.
- Clears the detector at the start of each frame and counts detector pulses.
- Reports the per-frame match count, a done pulse and an underrun error.

Parameters:
- W, 8, data word width in bits (W >= 2).
- CNT_W, 8, match counter width; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  word offered
- in_ready  output  1  word accepted when in_valid & in_ready at a clk edge
- in_data  input  W  word; MSB is shifted first
- in_last  input  1  qualifies in_data as the final word of the frame
- det_rst  output  1  reset to the detector (its async active-high reset)
- det_i  output  1  serial bit to the detector
- det_y  input  1  detector Moore output; high for one cycle per detection
- match_cnt  output  CNT_W  matches in the current or last frame
- frame_done  output  1  one-cycle pulse at the end of a frame
- err  output  1  underrun in the last frame
- busy  output  1  state != IDLE

Behaviour:
- Decided: reset rst, asynchronous, active-high; clock clk.
- Reset values: state IDLE, match_cnt 0, frame_done 0, err 0, det_i 0, shift register 0.
- While rst is high: det_rst = 1 and in_ready = 0.
- det_rst = rst | (state == CLR). It is combinational.
- The detector advances every clock. det_i is therefore 0 in every state except SHIFT.

FSM states: IDLE, CLR, SHIFT, DRAIN, DONE.
- IDLE: in_ready = 1. On handshake: load sreg <= in_data, last_q <= in_last, go to CLR.
- CLR (1 cycle):
  - det_rst = 1.
  - match_cnt <= 0, err <= 0, bitcnt <= W-1.
  - Go to SHIFT.
- SHIFT:
  - det_i = sreg[W-1]. Each cycle: sreg <<= 1 and bitcnt decrements.
  - Last bit cycle is bitcnt == 0.
  - in_ready = 1 only in the last bit cycle and only when last_q == 0.
  - If handshake occurs in the last bit cycle: reload sreg and last_q, set bitcnt <= W-1, stay in SHIFT. The next word's MSB is driven on the very next cycle, with no gap.
  - If last_q == 1 at the last bit: go to DRAIN.
  - If last_q == 0 and in_valid == 0 at the last bit: this is an underrun. Set err <= 1 and go to DRAIN. The frame is aborted, with no stall.
- DRAIN (1 cycle): det_i = 0. This cycle exists so the detector's response to the final bit can be sampled. Go to DONE.
- DONE (1 cycle): frame_done = 1, go to IDLE.

Match counting:
- bit_q is a register set when a frame bit was driven in the previous cycle (SHIFT), cleared otherwise.
- When bit_q & det_y: match_cnt <= match_cnt + 1, saturating at all-ones.
- det_y is ignored in every other cycle.
- match_cnt and err hold from DONE until the next CLR.

Latency:
- First-word handshake at edge T gives CLR in T+1.
- Bits are driven in T+2 .. T+W+1 for a single-word frame.
- DRAIN is at T+W+2 and frame_done at T+W+3.
- Each additional back-to-back word adds W cycles.

Boundary conditions:
- in_valid while busy and not in the last bit cycle is ignored. The source holds the word.
- Words are never accepted in CLR, DRAIN or DONE.
- Reset mid-frame aborts immediately: no frame_done, match_cnt = 0.
- Matches spanning word boundaries are counted, because the stream is continuous.

Test Plan:
1. Single-word frame, in_data = 8'h0A, last = 1:
   - det_i sequence is 0,0,0,0,1,0,1,0.
   - frame_done occurs 11 cycles after the handshake.
   - Final state: match_cnt = 1, err = 0.
2. 8'hAA, last = 1 (overlap case): match_cnt = 3, err = 0.
3. Two words back-to-back, 8'h01 then 8'h40 (last = 1), with the second presented at the first word's last-bit cycle:
   - det_i is continuous for 16 cycles.
   - Final state: match_cnt = 1 (cross-boundary match), frame_done 19 cycles after the first handshake.
4. 8'h0A with last = 0 and in_valid low at the last bit:
   - Sequence is DRAIN, then DONE with err = 1.
   - Final state: match_cnt = 1, in_ready returns high in IDLE.
5. CNT_W = 2 with frames 8'hAA, 8'hAA (last):
   - Seven detections occur.
   - match_cnt saturates at 3, no wrap.
6. Assert rst during the 4th bit of SHIFT:
   - Immediately: det_rst = 1, in_ready = 0, match_cnt = 0, det_i = 0, no frame_done.
   - After release: an 8'h0A frame yields match_cnt = 1.

Source files
------------

// File: rtl/seq_det_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_ctrl_if
// Description : Word stream handshake for seq_det_ctrl (valid/ready with
//               frame-last qualifier). W must match the controller's W.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_det_ctrl_if #(
  parameter int W = 8
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;

  // Word source side
  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  // Controller side
  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface
`default_nettype wire

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_ctrl
// Description : Frame controller for an external serial Moore "1010"
//               detector. Serializes accepted words MSB-first with no gaps
//               inside a frame, clears the detector per frame, counts its
//               pulses (saturating) and flags input underrun.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_ctrl #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  seq_det_ctrl_if.slave    s_in,
  output logic             det_rst,
  output logic             det_i,
  input  wire logic        det_y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             frame_done,
  output logic             err,
  output logic             busy
);

  localparam int BCW = (W > 1) ? $clog2(W) : 1;
  localparam logic [BCW-1:0] C_BIT_LAST = BCW'(W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       sreg_q, sreg_d;
  logic               last_q, last_d;
  logic [BCW-1:0]     bitcnt_q, bitcnt_d;
  logic               bit_q, bit_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic               err_q, err_d;
  logic               in_ready_w;

  // State and datapath registers; async reset returns everything to idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      last_q      <= 1'b0;
      bitcnt_q    <= '0;
      bit_q       <= 1'b0;
      match_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      last_q      <= last_d;
      bitcnt_q    <= bitcnt_d;
      bit_q       <= bit_d;
      match_cnt_q <= match_cnt_d;
      err_q       <= err_d;
    end
  end

  // Next-state, serializer, match counting and per-state outputs
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    last_d      = last_q;
    bitcnt_d    = bitcnt_q;
    err_d       = err_q;
    match_cnt_d = match_cnt_q;
    bit_d       = 1'b0;
    in_ready_w  = 1'b0;
    det_i       = 1'b0;
    frame_done  = 1'b0;

    // The detector output reflects the bit driven one cycle earlier, so only
    // pulses following a real frame bit are counted.
    if (bit_q && det_y && (match_cnt_q != '1)) begin
      match_cnt_d = match_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        in_ready_w = 1'b1;
        if (s_in.in_valid) begin
          sreg_d  = s_in.in_data;
          last_d  = s_in.in_last;
          state_d = CLR;
        end
      end

      CLR: begin
        match_cnt_d = '0;
        err_d       = 1'b0;
        bitcnt_d    = C_BIT_LAST;
        state_d     = SHIFT;
      end

      SHIFT: begin
        det_i    = sreg_q[W-1];
        bit_d    = 1'b1;
        sreg_d   = {sreg_q[W-2:0], 1'b0};
        bitcnt_d = bitcnt_q - 1'b1;
        if (bitcnt_q == '0) begin
          if (last_q) begin
            state_d = DRAIN;
          end else begin
            // Next word may only join the stream on the final bit so the
            // serial output stays gap-free; otherwise the frame is aborted.
            in_ready_w = 1'b1;
            if (s_in.in_valid) begin
              sreg_d   = s_in.in_data;
              last_d   = s_in.in_last;
              bitcnt_d = C_BIT_LAST;
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end
        end
      end

      DRAIN: begin
        state_d = DONE;
      end

      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign s_in.in_ready = in_ready_w & ~rst;
  assign det_rst       = rst | (state_q == CLR);
  assign busy          = (state_q != IDLE);
  assign match_cnt     = match_cnt_q;
  assign err           = err_q;

endmodule
`default_nettype wire
